// File: rtl/sram_1r1w_init_array.sv
`default_nettype none
// ============================================================================
// sram_1r1w_init_array: 1R1W SRAM model with segment write mask and init sweep
// Revision: 1.0
// ============================================================================
module sram_1r1w_init_array #(
    parameter int               DEPTH      = 1024,
    parameter int               WIDTH      = 7,
    parameter int               MASK_SEG   = 1,
    parameter int               BYPASS     = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [AW-1:0]       R0_addr,
    input  logic                R0_en,
    output logic [WIDTH-1:0]    R0_data,
    input  logic [AW-1:0]       W0_addr,
    input  logic                W0_en,
    input  logic [WIDTH-1:0]    W0_data,
    input  logic [MASK_SEG-1:0] W0_mask,
    output logic                init_done
);

    localparam int            SEG_W   = WIDTH / MASK_SEG;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [AW-1:0]    cnt;
    logic             sweep_we;
    logic             ready;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_in_range;
    logic             rd_in_range;
    logic             user_we;
    logic             collide;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] rd_old;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rd_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (cnt == LAST) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        sweep_we = 1'b0;
        ready    = 1'b0;
        case (state)
            ST_INIT:  sweep_we = 1'b1;
            ST_READY: ready    = 1'b1;
            default:  ;
        endcase
    end

    assign init_done = ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (sweep_we) begin
            cnt <= cnt + AW'(1);
        end
    end

    // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
    assign wr_in_range = {1'b0, W0_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, R0_addr} < DEPTH_W;
    assign user_we     = ready && W0_en && wr_in_range;

    assign wr_old = mem[W0_addr];
    assign rd_old = mem[R0_addr];

    for (genvar i = 0; i < MASK_SEG; i++) begin : g_seg
        assign merged[(i+1)*SEG_W-1 -: SEG_W] =
            W0_mask[i] ? W0_data[(i+1)*SEG_W-1 -: SEG_W]
                       : wr_old[(i+1)*SEG_W-1 -: SEG_W];
    end

    if (BYPASS != 0) begin : g_bypass_new
        assign collide = user_we && (W0_addr == R0_addr);
    end else begin : g_bypass_old
        assign collide = 1'b0;
    end

    always_comb begin
        rd_next = rd_old;
        if (!rd_in_range) begin
            rd_next = '0;
        end else if (collide) begin
            rd_next = merged;
        end
    end

    // Full-word write of the merged value keeps unmasked segments intact.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (sweep_we) begin
                mem[cnt] <= INIT_VALUE;
            end else if (user_we) begin
                mem[W0_addr] <= merged;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            R0_data <= '0;
        end else if (ready && R0_en) begin
            R0_data <= rd_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_1r1w_init_array.sv
`default_nettype none
// ============================================================================
// tb_sram_1r1w_init_array: two configurations checked against an array model
// Revision: 1.0
// ============================================================================
module tb_sram_1r1w_init_array;

    logic       clock;
    logic       reset;
    logic [3:0] R0_addr;
    logic       R0_en;
    logic [3:0] W0_addr;
    logic       W0_en;
    logic [7:0] W0_data;
    logic [1:0] W0_mask;
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    logic       done_a;
    logic       done_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance A: power-of-two depth, new-data bypass.
    sram_1r1w_init_array #(
        .DEPTH(16), .WIDTH(8), .MASK_SEG(2), .BYPASS(1), .INIT_VALUE(8'hA5)
    ) dut_a (
        .clock(clock), .reset(reset),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rd_a),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
        .init_done(done_a)
    );

    // Instance B: non-power-of-two depth, old-data read-during-write.
    sram_1r1w_init_array #(
        .DEPTH(12), .WIDTH(8), .MASK_SEG(2), .BYPASS(0), .INIT_VALUE(8'hA5)
    ) dut_b (
        .clock(clock), .reset(reset),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rd_b),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
        .init_done(done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] mm [2][16];
    int         dep [2] = '{16, 12};
    int         byp [2] = '{1, 0};
    int         icnt [2];
    logic       rdy [2];
    logic [7:0] erd [2];
    logic       started = 1'b0;

    function automatic logic [7:0] merge(input logic [7:0] old_w,
                                         input logic [7:0] new_w,
                                         input logic [1:0] m);
        logic [7:0] r;
        r = old_w;
        if (m[0]) r[3:0] = new_w[3:0];
        if (m[1]) r[7:4] = new_w[7:4];
        return r;
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                icnt[k] = 0;
                rdy[k]  = 1'b0;
                erd[k]  = 8'h00;
            end else if (!rdy[k]) begin
                mm[k][icnt[k]] = 8'hA5;
                icnt[k] = icnt[k] + 1;
                if (icnt[k] == dep[k]) rdy[k] = 1'b1;
            end else begin
                if (R0_en) begin
                    if (int'(R0_addr) >= dep[k])
                        erd[k] = 8'h00;
                    else if (byp[k] == 1 && W0_en && W0_addr == R0_addr)
                        erd[k] = merge(mm[k][R0_addr], W0_data, W0_mask);
                    else
                        erd[k] = mm[k][R0_addr];
                end
                if (W0_en && int'(W0_addr) < dep[k])
                    mm[k][W0_addr] = merge(mm[k][W0_addr], W0_data, W0_mask);
            end
        end
        if (reset) started = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            chk("model_rd_a",   32'(rd_a),   32'(erd[0]));
            chk("model_done_a", 32'(done_a), 32'(rdy[0]));
            chk("model_rd_b",   32'(rd_b),   32'(erd[1]));
            chk("model_done_b", 32'(done_b), 32'(rdy[1]));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ren, input logic [3:0] ra,
                         input logic wen, input logic [3:0] wa,
                         input logic [7:0] wd, input logic [1:0] wm);
        R0_en = ren; R0_addr = ra;
        W0_en = wen; W0_addr = wa; W0_data = wd; W0_mask = wm;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 2'b00);
        tick(); tick();
        reset = 1'b0;

        // Init sweep with both ports hammered; last writes target addresses B lacks.
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 4'($urandom_range(15)), 1'b1, 4'(12 + (k % 4)),
                  8'($urandom), 2'b11);
            tick();
            chk("init_done_a_timing", 32'(done_a), 32'(k >= 16));
            chk("init_done_b_timing", 32'(done_b), 32'(k >= 12));
            chk("init_rd_a_zero",     32'(rd_a),   32'h00);
        end

        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 4'(a), 1'b0, 4'd0, 8'h00, 2'b00);
            tick();
            chk("init_read_a", 32'(rd_a), 32'hA5);
            chk("init_read_b", 32'(rd_b), (a < 12) ? 32'hA5 : 32'h00);
        end

        // Masked writes to address 3.
        drive(1'b0, 4'd0, 1'b1, 4'd3, 8'h3C, 2'b01);
        tick();
        drive(1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 2'b00);
        tick();
        chk("mask_lo_a", 32'(rd_a), 32'hAC);
        chk("mask_lo_b", 32'(rd_b), 32'hAC);
        chk("pin_model_mask_lo", 32'(erd[0]), 32'hAC);
        drive(1'b0, 4'd0, 1'b1, 4'd3, 8'h71, 2'b10);
        tick();
        drive(1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 2'b00);
        tick();
        chk("mask_hi_a", 32'(rd_a), 32'h7C);
        chk("mask_hi_b", 32'(rd_b), 32'h7C);
        chk("pin_model_mask_hi", 32'(erd[1]), 32'h7C);

        // Same-address read during write.
        drive(1'b1, 4'd5, 1'b1, 4'd5, 8'hFF, 2'b11);
        tick();
        chk("rdw_bypass_new_a", 32'(rd_a), 32'hFF);
        chk("rdw_bypass_old_b", 32'(rd_b), 32'hA5);
        chk("pin_model_rdw_old", 32'(erd[1]), 32'hA5);
        drive(1'b1, 4'd5, 1'b0, 4'd0, 8'h00, 2'b00);
        tick();
        chk("rdw_after_a", 32'(rd_a), 32'hFF);
        chk("rdw_after_b", 32'(rd_b), 32'hFF);

        // Read data must hold while the entry is rewritten underneath.
        drive(1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 2'b00);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'd3, 1'b1, 4'd3, 8'h00, 2'b11);
            tick();
            chk("hold_a", 32'(rd_a), 32'h7C);
            chk("hold_b", 32'(rd_b), 32'h7C);
        end

        // Address 13 is out of range only for B.
        drive(1'b0, 4'd0, 1'b1, 4'd13, 8'h55, 2'b11);
        tick();
        drive(1'b1, 4'd13, 1'b0, 4'd0, 8'h00, 2'b00);
        tick();
        chk("oor_read_b", 32'(rd_b), 32'h00);
        chk("inrange_13_a", 32'(rd_a), 32'h55);
        drive(1'b1, 4'd1, 1'b0, 4'd0, 8'h00, 2'b00);
        tick();
        chk("no_alias_a", 32'(rd_a), 32'hA5);
        chk("no_alias_b", 32'(rd_b), 32'hA5);

        for (int c = 0; c < 2000; c++) begin
            logic [3:0] wa;
            wa = 4'($urandom_range(15));
            drive(1'($urandom), ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15)),
                  1'($urandom), wa, 8'($urandom), 2'($urandom));
            tick();
        end

        // Reset mid-sweep restarts from zero.
        drive(1'b1, 4'd1, 1'b0, 4'd0, 8'h00, 2'b00);
        reset = 1'b1;
        tick();
        chk("reset_rd_a", 32'(rd_a), 32'h00);
        chk("reset_rd_b", 32'(rd_b), 32'h00);
        reset = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        reset = 1'b1;
        tick();
        chk("midreset_done_a", 32'(done_a), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 4'($urandom_range(15)), 1'b1, 4'($urandom_range(15)),
                  8'($urandom), 2'b11);
            tick();
            chk("restart_done_a", 32'(done_a), 32'(k >= 16));
            chk("restart_done_b", 32'(done_b), 32'(k >= 12));
        end

        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom), 4'($urandom_range(15)), 1'($urandom),
                  4'($urandom_range(15)), 8'($urandom), 2'($urandom));
            tick();
        end

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
